// File: rtl/alu_fifo_sequencer.sv
// Sequencer that drains operand A, operand B and an opcode from the RX FIFO,
// drives the ALU with them, and pushes the one-byte result into the TX FIFO.
// An invalid opcode, or too long a wait between bytes, drops the partial
// transaction and pulses o_error. The sequencer then waits for a fresh operand A.
module alu_fifo_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic               o_rx_rd,
    input  logic               i_tx_full,
    output logic               o_tx_wr,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_error
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      idle_count;
    logic [NB_DATA-1:0] result_reg;
    logic               error_reg;
    logic               rx_rd;
    logic               tx_wr;
    logic               abort;
    logic               waiting_byte;
    logic               timeout_hit;
    logic [NB_OP-1:0]   opcode;
    logic               op_valid;

    // The opcode lives in the low bits of the RX word; the upper bits are ignored.
    assign opcode = i_rx_data[NB_OP-1:0];

    // Decode the set of opcodes the ALU implements.
    always_comb begin
        op_valid = 1'b0;
        case (opcode)
            NB_OP'('h20), NB_OP'('h22), NB_OP'('h24), NB_OP'('h25),
            NB_OP'('h26), NB_OP'('h27), NB_OP'('h03), NB_OP'('h02):
                op_valid = 1'b1;
            default:
                op_valid = 1'b0;
        endcase
    end

    // The timeout only applies while a transaction is partly received.
    assign waiting_byte = (state == GET_B) || (state == GET_OP);
    assign timeout_hit  = waiting_byte && i_rx_empty && (idle_count == TIMEOUT_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= GET_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A timeout or a bad opcode sends the FSM back to GET_A.
    always_comb begin
        next_state = state;
        case (state)
            GET_A: begin
                if (!i_rx_empty) next_state = GET_B;
            end
            GET_B: begin
                if (!i_rx_empty)      next_state = GET_OP;
                else if (timeout_hit) next_state = GET_A;
            end
            GET_OP: begin
                if (!i_rx_empty)      next_state = op_valid ? EXEC : GET_A;
                else if (timeout_hit) next_state = GET_A;
            end
            EXEC: begin
                next_state = SEND;
            end
            SEND: begin
                if (!i_tx_full) next_state = GET_A;
            end
            default: begin
                next_state = GET_A;
            end
        endcase
    end

    // Mealy strobes and the abort decision. Reset masks both strobes.
    always_comb begin
        rx_rd = 1'b0;
        tx_wr = 1'b0;
        abort = 1'b0;
        if (!i_reset) begin
            case (state)
                GET_A, GET_B: rx_rd = !i_rx_empty;
                GET_OP: begin
                    rx_rd = !i_rx_empty;
                    abort = !i_rx_empty && !op_valid;
                end
                SEND:    tx_wr = !i_tx_full;
                default: begin
                    rx_rd = 1'b0;
                    tx_wr = 1'b0;
                end
            endcase
            if (timeout_hit) abort = 1'b1;
        end
    end

    // Operand, opcode and result capture, the idle counter and the registered error pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            result_reg <= '0;
            idle_count <= '0;
            error_reg  <= 1'b0;
        end else begin
            if (rx_rd) begin
                case (state)
                    GET_A:   o_alu_a <= i_rx_data;
                    GET_B:   o_alu_b <= i_rx_data;
                    GET_OP:  if (op_valid) o_alu_op <= opcode;
                    default: o_alu_a <= o_alu_a;
                endcase
            end
            if (state == EXEC) begin
                result_reg <= i_alu_result;
            end
            if (rx_rd || timeout_hit || !waiting_byte) begin
                idle_count <= '0;
            end else begin
                idle_count <= idle_count + 1'b1;
            end
            error_reg <= abort;
        end
    end

    assign o_rx_rd   = rx_rd;
    assign o_tx_wr   = tx_wr;
    assign o_tx_data = result_reg;
    assign o_busy    = (state != GET_A);
    assign o_error   = error_reg;

endmodule
